// File: rtl/fifo_unpack_if.sv
// Wide-to-narrow FIFO bus: write side takes WRITE_SCALAR words per beat, read side pops one word.
// Latency: none, this is wiring only.
// Backpressure: producer must honour full; consumer must honour empty.
// Ports: clr, wr_en, din, rd_en (requests); full, almost_full, dout, empty,
//        almost_empty, count, overflow, underflow (status).
interface fifo_unpack_if #(
  parameter int WIDTH        = 8,
  parameter int WRITE_SCALAR = 11,
  parameter int DEPTH        = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                          clr;
  logic                          wr_en;
  logic [WIDTH*WRITE_SCALAR-1:0] din;
  logic                          full;
  logic                          almost_full;
  logic                          rd_en;
  logic [WIDTH-1:0]              dout;
  logic                          empty;
  logic                          almost_empty;
  logic [CW-1:0]                 count;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_unpack.sv
// Circular wide-to-narrow FIFO: one write stores WRITE_SCALAR words, each read pops one (lane 0 first).
// Latency: write at edge N is visible on dout/empty after edge N; dout is show-ahead.
// Backpressure: writes refused while full, reads refused while empty; refusals set sticky flags.
// Ports: clk, reset (async active-low), bus (fifo_unpack_if.slave carrying clr, wr_en/din,
//        rd_en/dout and the full/almost_full/empty/almost_empty/count/overflow/underflow status).
module fifo_unpack #(
  parameter int WIDTH               = 8,
  parameter int WRITE_SCALAR        = 11,
  parameter int DEPTH               = 16,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_unpack_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   ptr_x_t;   // one bit of headroom so ptr+offset never truncates
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   cnt_x_t;

  localparam ptr_x_t DEPTH_X   = ptr_x_t'(DEPTH);
  localparam ptr_x_t WS_X      = ptr_x_t'(WRITE_SCALAR);
  localparam cnt_x_t WS_CX     = cnt_x_t'(WRITE_SCALAR);
  localparam cnt_t   FULL_LIM  = cnt_t'(DEPTH - WRITE_SCALAR);
  localparam cnt_t   AF_THRESH = cnt_t'(ALMOST_FULL_THRESH);
  localparam cnt_t   AE_THRESH = cnt_t'(ALMOST_EMPTY_THRESH);

  if (WRITE_SCALAR > DEPTH) begin : g_bad_params
    $error("fifo_unpack: WRITE_SCALAR must not exceed DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             count;
  logic             overflow;
  logic             underflow;

  logic   full;
  logic   empty;
  logic   wr_acc;
  logic   rd_acc;
  ptr_t   lane_idx [WRITE_SCALAR];
  ptr_x_t wr_sum;
  ptr_t   wr_ptr_nxt;
  ptr_t   rd_ptr_nxt;
  cnt_x_t cnt_sum;

  assign full  = (count > FULL_LIM);
  assign empty = (count == '0);

  // clr wins over both requests; each side is judged on its own pre-edge flag.
  assign wr_acc = bus.wr_en && !full  && !bus.clr;
  assign rd_acc = bus.rd_en && !empty && !bus.clr;

  // Lane slots may wrap past DEPTH-1 back to 0; DEPTH need not be a power of two.
  always_comb begin
    ptr_x_t s;
    for (int i = 0; i < WRITE_SCALAR; i++) begin
      s           = {1'b0, wr_ptr} + ptr_x_t'(i);
      lane_idx[i] = ptr_t'((s >= DEPTH_X) ? (s - DEPTH_X) : s);
    end
  end

  assign wr_sum     = {1'b0, wr_ptr} + WS_X;
  assign wr_ptr_nxt = ptr_t'((wr_sum >= DEPTH_X) ? (wr_sum - DEPTH_X) : wr_sum);
  assign rd_ptr_nxt = (rd_ptr == ptr_t'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
  assign cnt_sum    = {1'b0, count} + (wr_acc ? WS_CX : '0) - (rd_acc ? cnt_x_t'(1) : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr_nxt;
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      count <= cnt_t'(cnt_sum);
      if (bus.wr_en && full)  overflow  <= 1'b1;
      if (bus.rd_en && empty) underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < WRITE_SCALAR; i++) begin
        mem[lane_idx[i]] <= bus.din[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.dout         = mem[rd_ptr];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_THRESH);
  assign bus.almost_empty = (count <= AE_THRESH);
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule

// File: tb/tb_fifo_unpack.sv
// Directed bench for fifo_unpack with a queue scoreboard of expected output words.
// Latency: checks status one cycle after each driven request; dout compared before each accepted pop.
// Backpressure: the reference model refuses writes when full and reads when empty, like the DUT.
module tb_fifo_unpack;
  localparam int W   = 8;
  localparam int WS  = 11;
  localparam int D   = 16;
  localparam int DW  = W * WS;
  localparam int AFT = D - 2;
  localparam int AET = 2;

  logic clk;
  logic reset;

  fifo_unpack_if #(.WIDTH(W), .WRITE_SCALAR(WS), .DEPTH(D)) bus ();

  fifo_unpack #(
    .WIDTH(W), .WRITE_SCALAR(WS), .DEPTH(D),
    .ALMOST_FULL_THRESH(AFT), .ALMOST_EMPTY_THRESH(AET)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] sb [$];
  int   m_count  = 0;
  logic m_ov     = 1'b0;
  logic m_un     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] blk(input logic [W-1:0] base);
    logic [DW-1:0] r;
    for (int i = 0; i < WS; i++) r[i*W +: W] = base + W'(i);
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(bus.count),       32'(m_count));
    check({tag, "_empty"}, 32'(bus.empty),       32'(m_count == 0));
    check({tag, "_full"},  32'(bus.full),        32'(m_count > D - WS));
    check({tag, "_af"},    32'(bus.almost_full), 32'(m_count >= AFT));
    check({tag, "_ae"},    32'(bus.almost_empty),32'(m_count <= AET));
    check({tag, "_ovf"},   32'(bus.overflow),    32'(m_ov));
    check({tag, "_unf"},   32'(bus.underflow),   32'(m_un));
  endtask

  // One clock of stimulus, driven from the falling edge; model updated from pre-edge state.
  task automatic cycle(input string tag, input logic w, input logic r, input logic c,
                       input logic [DW-1:0] d);
    logic wacc;
    logic racc;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.clr   = c;
    bus.din   = d;
    #1;
    if (c) begin
      model_reset();
    end else begin
      wacc = w && (m_count <= D - WS);
      racc = r && (m_count != 0);
      if (racc) begin
        check({tag, "_dout"}, 32'(bus.dout), 32'(sb.pop_front()));
        m_count--;
      end
      if (r && !racc) m_un = 1'b1;
      if (w && !wacc) m_ov = 1'b1;
      if (wacc) begin
        for (int i = 0; i < WS; i++) sb.push_back(d[i*W +: W]);
        m_count += WS;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
    check_status(tag);
  endtask

  initial begin
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
    bus.din   = '0;
    #12;
    check_status("reset");
    @(negedge clk);
    reset = 1'b1;

    // 1: single write, show-ahead lane 0
    cycle("t1_wr", 1'b1, 1'b0, 1'b0, blk(8'h01));
    check("t1_count", 32'(bus.count), 32'd11);
    check("t1_full",  32'(bus.full),  32'd1);
    check("t1_dout",  32'(bus.dout),  32'h01);

    // 2: drain eleven words
    for (int i = 0; i < WS; i++) cycle("t2_rd", 1'b0, 1'b1, 1'b0, '0);
    check("t2_empty", 32'(bus.empty),     32'd1);
    check("t2_unf",   32'(bus.underflow), 32'd0);

    // 3: refused write sets overflow, clr flushes
    cycle("t3_wr",  1'b1, 1'b0, 1'b0, blk(8'h01));
    cycle("t3_ovw", 1'b1, 1'b0, 1'b0, blk(8'h41));
    check("t3_count", 32'(bus.count),    32'd11);
    check("t3_ovf",   32'(bus.overflow), 32'd1);
    cycle("t3_clr", 1'b1, 1'b1, 1'b1, blk(8'h51));
    check("t3_clr_count", 32'(bus.count),    32'd0);
    check("t3_clr_ovf",   32'(bus.overflow), 32'd0);
    check("t3_clr_unf",   32'(bus.underflow),32'd0);

    // 4: simultaneous read and write at count 5
    cycle("t4_wr", 1'b1, 1'b0, 1'b0, blk(8'h01));
    for (int i = 0; i < 6; i++) cycle("t4_rd", 1'b0, 1'b1, 1'b0, '0);
    check("t4_count5", 32'(bus.count), 32'd5);
    cycle("t4_rw", 1'b1, 1'b1, 1'b0, blk(8'h21));
    check("t4_count", 32'(bus.count),       32'd15);
    check("t4_af",    32'(bus.almost_full), 32'd1);

    // 5: drain across the slot 15 -> 0 boundary
    for (int i = 0; i < 15; i++) cycle("t5_rd", 1'b0, 1'b1, 1'b0, '0);
    check("t5_empty",  32'(bus.empty),  32'd1);
    check("t5_sb",     32'(sb.size()),  32'd0);
    check("t5_rd_ptr", 32'(dut.rd_ptr), 32'd6);

    // 6: underflow, then async reset between edges
    cycle("t6_unf", 1'b0, 1'b1, 1'b0, '0);
    check("t6_unf_flag", 32'(bus.underflow), 32'd1);
    check("t6_rd_ptr",   32'(dut.rd_ptr),    32'd6);
    cycle("t6_wr", 1'b1, 1'b0, 1'b0, blk(8'h61));
    check("t6_count", 32'(bus.count), 32'd11);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_status("t6_arst");
    @(negedge clk);
    reset = 1'b1;
    cycle("t6_post", 1'b1, 1'b0, 1'b0, blk(8'h21));
    check("t6_post_dout",   32'(bus.dout),   32'h21);
    check("t6_post_wr_ptr", 32'(dut.wr_ptr), 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
